// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle between byte-stream requesters, the arbiter and the Uart_core TX FIFO
//   req_valid/req_data/req_last/req_ready : per-requester byte stream (requester i owns req_data[8*i+7:8*i])
//   tx_fifo_full/tx_fifo_empty            : status from Uart_core
//   wr_uart/wr_data/send                  : push strobe, byte and transmit enable to Uart_core
//   grant_id/busy                         : current owner and transfer-in-progress flag
//   modport master = arbiter side, modport slave = client/core side
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
    localparam int GID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_fifo_full;
    logic                 tx_fifo_empty;
    logic                 wr_uart;
    logic [7:0]           wr_data;
    logic                 send;
    logic [GID_W-1:0]     grant_id;
    logic                 busy;
    modport master (
        input  req_valid, req_data, req_last, tx_fifo_full, tx_fifo_empty,
        output req_ready, wr_uart, wr_data, send, grant_id, busy
    );
    modport slave (
        output req_valid, req_data, req_last, tx_fifo_full, tx_fifo_empty,
        input  req_ready, wr_uart, wr_data, send, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART TX FIFO among NUM_REQ byte streams
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : requester streams in, FIFO push/send out, grant_id/busy status out
//   UART_ARB_PRIO0_EN : when defined, requester 0 wins every arbitration it is valid for
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int GID_W     = $clog2(NUM_REQ)
) (
    input logic clock,
    input logic reset,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic {IDLE, XFER} state_t;
    state_t state;
    logic [GID_W-1:0] rr_ptr, pick, idx;
    logic [7:0] burst_cnt;
    logic [NUM_REQ-1:0] cand;
    logic xfer, hs, done;
    // First valid candidate after rr_ptr; descending scan so the nearest offset wins.
    always_comb begin
        cand = bus.req_valid;
`ifdef UART_ARB_PRIO0_EN
        cand[0] = 1'b0;
`endif
        pick = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = GID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (cand[idx]) pick = idx;
        end
`ifdef UART_ARB_PRIO0_EN
        if (bus.req_valid[0]) pick = '0;
`endif
    end
    assign xfer = (state == XFER);
    assign hs = xfer & bus.req_valid[bus.grant_id] & ~bus.tx_fifo_full;
    // A stalled FIFO is not a burst end; only last, burst limit or a dropped valid end it.
    assign done = xfer & (~bus.req_valid[bus.grant_id] |
                  (hs & (bus.req_last[bus.grant_id] | burst_cnt == 8'(MAX_BURST - 1))));
    assign bus.busy = xfer;
    assign bus.wr_uart = hs;
    assign bus.wr_data = xfer ? bus.req_data[8*bus.grant_id +: 8] : 8'h00;
    assign bus.req_ready = (xfer & ~bus.tx_fifo_full) ?
                           {{(NUM_REQ-1){1'b0}}, 1'b1} << bus.grant_id : '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= GID_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            bus.grant_id <= '0;
            bus.send <= 1'b0;
        end else begin
            bus.send <= ~bus.tx_fifo_empty;
            if (state == IDLE) begin
                if (|bus.req_valid) begin
                    state <= XFER;
                    bus.grant_id <= pick;
                    burst_cnt <= '0;
                end
            end else begin
                if (hs) burst_cnt <= burst_cnt + 8'd1;
                if (done) begin
                    state <= IDLE;
`ifdef UART_ARB_PRIO0_EN
                    if (bus.grant_id != '0) rr_ptr <= bus.grant_id;
`else
                    rr_ptr <= bus.grant_id;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests with a per-cycle reference model and byte scoreboard
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int MB = 8;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [7:0] q[N][$];
    logic ql[N][$];
    logic [7:0] sent[N][$];
    logic [7:0] got[N][$];
    logic [N-1:0] acc;
    int checks = 0;
    int failures = 0;
    int busy_cycles = 0;
    int wr_cnt = 0;
    logic chk_en = 1'b0;

    // Reference model: owner, round-robin pointer, bytes taken this burst.
    logic m_busy = 1'b0, m_send = 1'b0;
    logic [1:0] m_gid = 2'd0, m_rr = 2'd3;
    int m_cnt = 0;
    int m_grants[$];

    function automatic logic [1:0] arb(logic [N-1:0] v, logic [1:0] rr);
`ifdef UART_ARB_PRIO0_EN
        if (v[0]) return 2'd0;
        v[0] = 1'b0;
`endif
        for (int off = 1; off <= N; off++)
            if (v[(int'(rr) + off) % N]) return 2'((int'(rr) + off) % N);
        return 2'd0;
    endfunction

    logic take, endb;
    logic [1:0] nxt;
    assign take = m_busy && bus.req_valid[m_gid] && !bus.tx_fifo_full;
    assign endb = (take && (bus.req_last[m_gid] || m_cnt + 1 == MB)) || !bus.req_valid[m_gid];
    assign nxt = arb(bus.req_valid, m_rr);

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_send <= 1'b0;
            m_gid <= 2'd0;
            m_rr <= 2'd3;
            m_cnt <= 0;
        end else begin
            m_send <= !bus.tx_fifo_empty;
            if (!m_busy) begin
                if (bus.req_valid != '0) begin
                    m_busy <= 1'b1;
                    m_gid <= nxt;
                    m_cnt <= 0;
                    m_grants.push_back(int'(nxt));
                end
            end else begin
                if (take) m_cnt <= m_cnt + 1;
                if (endb) begin
                    m_busy <= 1'b0;
`ifdef UART_ARB_PRIO0_EN
                    if (m_gid != 2'd0) m_rr <= m_gid;
`else
                    m_rr <= m_gid;
`endif
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = q[i].size() > 0;
            bus.req_data[8*i +: 8] = q[i].size() > 0 ? q[i][0] : 8'h00;
            bus.req_last[i] = q[i].size() > 0 ? ql[i][0] : 1'b0;
        end
    endtask

    task automatic step();
        logic [3:0] er;
        @(negedge clock);
        if (chk_en) begin
            er = (m_busy && !bus.tx_fifo_full) ? (4'b0001 << m_gid) : 4'b0000;
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
            chk("send", 32'(bus.send), 32'(m_send));
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            chk("wr_uart", 32'(bus.wr_uart), 32'(take));
            if (take) chk("wr_data", 32'(bus.wr_data), 32'(bus.req_data[8*m_gid +: 8]));
        end
        acc = bus.req_valid & bus.req_ready;
        if (bus.busy) busy_cycles++;
        if (bus.wr_uart) begin
            wr_cnt++;
            got[bus.grant_id].push_back(bus.wr_data);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                void'(q[i].pop_front());
                void'(ql[i].pop_front());
            end
        drive();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(int r, logic [7:0] d, logic l);
        q[r].push_back(d);
        ql[r].push_back(l);
        sent[r].push_back(d);
    endtask

    task automatic pkt(int r, logic [7:0] base, int n, logic with_last);
        for (int i = 0; i < n; i++) load(r, base + 8'(i), with_last && i == n - 1);
    endtask

    // Expected grant sequence packed as hex digits, first grant in the most significant digit.
    task automatic chk_grants(string name, int start, int cnt, logic [31:0] seq);
        for (int i = 0; i < cnt; i++)
            chk($sformatf("%s[%0d]", name, i),
                start + i < m_grants.size() ? 32'(m_grants[start + i]) : 32'hffffffff,
                32'(seq[4*(cnt-1-i) +: 4]));
    endtask

    int s, b0, w0;
    logic [31:0] seq;
    initial begin
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.tx_fifo_full = 1'b0;
        bus.tx_fifo_empty = 1'b1;
        step();
        chk_en = 1'b1;
        steps(2);
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_wr_uart", 32'(bus.wr_uart), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_send", 32'(bus.send), 0);

        // single requester 1, three bytes
        s = m_grants.size(); b0 = busy_cycles; w0 = wr_cnt;
        load(1, 8'hA1, 0); load(1, 8'hA2, 0); load(1, 8'hA3, 1);
        steps(8);
        chk_grants("t1_grant", s, 1, 32'h1);
        chk("t1_busy_cycles", 32'(busy_cycles - b0), 3);
        chk("t1_writes", 32'(wr_cnt - w0), 3);
        chk("t1_byte0", 32'(got[1].size() > 0 ? got[1][0] : 8'h00), 32'hA1);
        chk("t1_byte2", 32'(got[1].size() > 2 ? got[1][2] : 8'h00), 32'hA3);

        // all four requesters from reset
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        s = m_grants.size();
        pkt(0, 8'h01, 2, 1); pkt(0, 8'h05, 2, 1);
        pkt(1, 8'h11, 2, 1); pkt(2, 8'h21, 2, 1); pkt(3, 8'h31, 2, 1);
        steps(25);
`ifdef UART_ARB_PRIO0_EN
        seq = 32'h00123;
`else
        seq = 32'h01230;
`endif
        chk_grants("t2_grant", s, 5, seq);

        // long stream from requester 2 is cut at the burst limit
        s = m_grants.size();
        pkt(2, 8'h40, 20, 0);
        steps(2);
        pkt(3, 8'h90, 2, 1);
        steps(40);
        chk_grants("t3_grant", s, 4, 32'h2322);

        // FIFO full for five cycles mid-burst
        s = m_grants.size(); b0 = busy_cycles; w0 = wr_cnt;
        bus.tx_fifo_empty = 1'b0;
        pkt(1, 8'hB0, 4, 1);
        steps(3);
        bus.tx_fifo_full = 1'b1;
        steps(5);
        bus.tx_fifo_full = 1'b0;
        steps(8);
        chk_grants("t4_grant", s, 1, 32'h1);
        chk("t4_busy_cycles", 32'(busy_cycles - b0), 9);
        chk("t4_writes", 32'(wr_cnt - w0), 4);

        // reset during the second byte of a four-byte packet
        s = m_grants.size();
        pkt(3, 8'h51, 4, 1);
        steps(3);
        reset = 1'b1;
        step();
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_grant_id", 32'(bus.grant_id), 0);
        chk("t5_wr_uart", 32'(bus.wr_uart), 0);
        chk("t5_req_ready", 32'(bus.req_ready), 0);
        chk("t5_send", 32'(bus.send), 0);
        pkt(0, 8'h61, 2, 1);
        step();
        reset = 1'b0;
        steps(15);
        chk_grants("t5_grant", s, 3, 32'h303);

        // requesters 0 and 3 continually valid
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        s = m_grants.size();
        for (int k = 0; k < 3; k++) begin
            pkt(0, 8'h70 + 8'(2*k), 2, 1);
            pkt(3, 8'h80 + 8'(2*k), 2, 1);
        end
        steps(30);
`ifdef UART_ARB_PRIO0_EN
        seq = 32'h000333;
`else
        seq = 32'h030303;
`endif
        chk_grants("t6_grant", s, 6, seq);

        // every loaded byte delivered exactly once, in order, under its owner's grant
        for (int r = 0; r < N; r++) begin
            chk($sformatf("sb_count_%0d", r), 32'(got[r].size()), 32'(sent[r].size()));
            for (int i = 0; i < sent[r].size() && i < got[r].size(); i++)
                chk($sformatf("sb_byte_%0d_%0d", r, i), 32'(got[r][i]), 32'(sent[r][i]));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
